ext_mem_arbiter: RTL and testbench

Round-robin arbiter that shares the single external-memory IOb slave port (the iob2axi bridge) between N IOb masters, such as the instruction and data cache back-ends.
- Holds each grant until the address phase completes.
- For reads, holds the grant further until the read response returns.
- Routes read responses only to the owning master.
- Aborts stalled reads with a response timeout.
- Sits between the cache back-ends and the iob2axi instance inside the external-memory wrapper.

---
 rtl/ext_mem_arbiter_pkg.sv | 32 +++
 rtl/ext_mem_arbiter_if.sv | 46 ++++
 rtl/ext_mem_arbiter_rr_pick.sv | 38 +++
 rtl/ext_mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_ext_mem_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ext_mem_arbiter_pkg.sv
// rtl/ext_mem_arbiter_pkg.sv - shared types and helpers for the external-memory arbiter
// Contents:
//   arb_state_t  arbiter FSM encoding (IDLE=0, ADDR=1, RDATA=2)
//   BYTE_W       bits covered by one write-strobe bit
//   ERR_IDX_W    width of the reported error-owner index
//   owner_w()    master-index width, clog2(n) with a minimum of 1
//   slice_lsb()  lsb of field k inside a flattened per-master bus
package ext_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_RDATA = 2'd2
    } arb_state_t;

    localparam int BYTE_W    = 8;
    localparam int ERR_IDX_W = 2;

    function automatic int owner_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

    function automatic int slice_lsb(input int idx, input int field_w);
        return idx * field_w;
    endfunction

endpackage

// File: rtl/ext_mem_arbiter_if.sv
// rtl/ext_mem_arbiter_if.sv - IOb master-side and slave-side bus bundle for the arbiter
// Signals:
//   m_avalid_i/m_addr_i/m_wdata_i/m_wstrb_i  flattened per-master requests (master k at slice k)
//   m_rdata_o/m_rvalid_o/m_ready_o           responses back to the masters
//   s_avalid_o/s_addr_o/s_wdata_o/s_wstrb_o  request towards the shared slave
//   s_rdata_i/s_rvalid_i/s_ready_i           slave response
// Modports:
//   slave   the arbiter's view (takes master requests, drives the slave port)
//   master  the surrounding logic's view (cache back-ends plus the iob2axi bridge)
interface ext_mem_arbiter_if
    import ext_mem_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    logic [N_MASTERS-1:0]                 m_avalid_i;
    logic [N_MASTERS*ADDR_W-1:0]          m_addr_i;
    logic [N_MASTERS*DATA_W-1:0]          m_wdata_i;
    logic [N_MASTERS*(DATA_W/BYTE_W)-1:0] m_wstrb_i;
    logic [DATA_W-1:0]                    m_rdata_o;
    logic [N_MASTERS-1:0]                 m_rvalid_o;
    logic [N_MASTERS-1:0]                 m_ready_o;
    logic                                 s_avalid_o;
    logic [ADDR_W-1:0]                    s_addr_o;
    logic [DATA_W-1:0]                    s_wdata_o;
    logic [DATA_W/BYTE_W-1:0]             s_wstrb_o;
    logic [DATA_W-1:0]                    s_rdata_i;
    logic                                 s_rvalid_i;
    logic                                 s_ready_i;

    modport slave (
        input  m_avalid_i, m_addr_i, m_wdata_i, m_wstrb_i,
        input  s_rdata_i, s_rvalid_i, s_ready_i,
        output m_rdata_o, m_rvalid_o, m_ready_o,
        output s_avalid_o, s_addr_o, s_wdata_o, s_wstrb_o
    );

    modport master (
        output m_avalid_i, m_addr_i, m_wdata_i, m_wstrb_i,
        output s_rdata_i, s_rvalid_i, s_ready_i,
        input  m_rdata_o, m_rvalid_o, m_ready_o,
        input  s_avalid_o, s_addr_o, s_wdata_o, s_wstrb_o
    );

endinterface

// File: rtl/ext_mem_arbiter_rr_pick.sv
// rtl/ext_mem_arbiter_rr_pick.sv - combinational round-robin priority picker
// Ports:
//   req      request vector, one bit per requester
//   last     index of the most recently served requester (lowest priority)
//   winner   first requesting index scanning last+1, last+2, ... modulo N
//   any_req  at least one request is present
module rr_pick
    import ext_mem_arbiter_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = owner_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] winner,
    output logic          any_req
);

    // One extra bit so last+i (at most 2N-1) never wraps before the modulo fold.
    logic [IW:0] cand;

    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int i = 1; i <= N; i++) begin
            cand = {1'b0, last} + (IW+1)'(i);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!any_req && req[cand[IW-1:0]]) begin
                any_req = 1'b1;
                winner  = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/ext_mem_arbiter.sv
// rtl/ext_mem_arbiter.sv - round-robin arbiter sharing one IOb slave between N masters
// Ports:
//   clk_i         clock
//   arst_n_i      asynchronous reset, active-low
//   cke_i         clock enable; low freezes state and blocks new requests
//   bus           ext_mem_arbiter_if.slave: master requests in, slave port out
//   busy_o        arbiter is holding a grant (ADDR or RDATA)
//   err_o         one-cycle pulse when a read response timed out
//   err_master_o  owner of the last timed-out read, held until the next one
module ext_mem_arbiter
    import ext_mem_arbiter_pkg::*;
#(
    parameter int N_MASTERS    = 2,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int RESP_TIMEOUT = 1024
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic                 cke_i,
    ext_mem_arbiter_if.slave     bus,
    output logic                 busy_o,
    output logic                 err_o,
    output logic [ERR_IDX_W-1:0] err_master_o
);

    localparam int OW = owner_w(N_MASTERS);
    localparam int SW = DATA_W / BYTE_W;
    localparam int TW = $clog2(RESP_TIMEOUT);

    // Master N-1 starts as "last served" so master 0 wins the first arbitration.
    localparam logic [OW-1:0] LAST_RST = OW'(N_MASTERS - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(RESP_TIMEOUT - 1);

    arb_state_t state_q, state_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic [OW-1:0]        last_q, last_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic                 err_q, err_d;
    logic [ERR_IDX_W-1:0] err_master_q, err_master_d;

    logic [OW-1:0]        win;
    logic                 any_req;
    logic                 active;

    logic [ADDR_W-1:0]    m_addr  [N_MASTERS];
    logic [DATA_W-1:0]    m_wdata [N_MASTERS];
    logic [SW-1:0]        m_wstrb [N_MASTERS];

    logic                 s_avalid;
    logic [ADDR_W-1:0]    s_addr;
    logic [DATA_W-1:0]    s_wdata;
    logic [SW-1:0]        s_wstrb;
    logic [N_MASTERS-1:0] m_ready;
    logic [N_MASTERS-1:0] m_rvalid;

    for (genvar k = 0; k < N_MASTERS; k++) begin : g_split
        assign m_addr[k]  = bus.m_addr_i[slice_lsb(k, ADDR_W) +: ADDR_W];
        assign m_wdata[k] = bus.m_wdata_i[slice_lsb(k, DATA_W) +: DATA_W];
        assign m_wstrb[k] = bus.m_wstrb_i[slice_lsb(k, SW) +: SW];
    end

    rr_pick #(
        .N  (N_MASTERS),
        .IW (OW)
    ) u_pick (
        .req     (bus.m_avalid_i),
        .last    (last_q),
        .winner  (win),
        .any_req (any_req)
    );

    // Handshakes are suppressed while frozen or held in reset so no master
    // sees an accept that the registers will not record.
    assign active = cke_i & arst_n_i;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_q       <= LAST_RST;
            tmo_q        <= '0;
            err_q        <= 1'b0;
            err_master_q <= '0;
        end else if (cke_i) begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            tmo_q        <= tmo_d;
            err_q        <= err_d;
            err_master_q <= err_master_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        tmo_d        = tmo_q;
        err_d        = 1'b0;
        err_master_d = err_master_q;
        s_avalid     = 1'b0;
        s_addr       = '0;
        s_wdata      = '0;
        s_wstrb      = '0;
        m_ready      = '0;
        m_rvalid     = '0;

        case (state_q)
            ST_IDLE: begin
                // Zero-latency path: the winner's request reaches the slave this cycle.
                if (any_req) begin
                    s_avalid     = 1'b1;
                    s_addr       = m_addr[win];
                    s_wdata      = m_wdata[win];
                    s_wstrb      = m_wstrb[win];
                    m_ready[win] = bus.s_ready_i;
                    owner_d      = win;
                    if (bus.s_ready_i) begin
                        last_d  = win;
                        tmo_d   = '0;
                        state_d = (m_wstrb[win] == '0) ? ST_RDATA : ST_IDLE;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
            end

            ST_ADDR: begin
                // The owner abandoning its request is a protocol violation; just release.
                if (!bus.m_avalid_i[owner_q]) begin
                    state_d = ST_IDLE;
                end else begin
                    s_avalid         = 1'b1;
                    s_addr           = m_addr[owner_q];
                    s_wdata          = m_wdata[owner_q];
                    s_wstrb          = m_wstrb[owner_q];
                    m_ready[owner_q] = bus.s_ready_i;
                    if (bus.s_ready_i) begin
                        last_d  = owner_q;
                        tmo_d   = '0;
                        state_d = (m_wstrb[owner_q] == '0) ? ST_RDATA : ST_IDLE;
                    end
                end
            end

            ST_RDATA: begin
                // A response arriving on the timeout cycle still wins.
                if (bus.s_rvalid_i) begin
                    m_rvalid[owner_q] = 1'b1;
                    tmo_d             = '0;
                    state_d           = ST_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d        = 1'b1;
                    err_master_d = ERR_IDX_W'(owner_q);
                    tmo_d        = '0;
                    state_d      = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!active) begin
            s_avalid = 1'b0;
            s_addr   = '0;
            s_wdata  = '0;
            s_wstrb  = '0;
            m_ready  = '0;
            m_rvalid = '0;
        end
    end

    assign bus.s_avalid_o = s_avalid;
    assign bus.s_addr_o   = s_addr;
    assign bus.s_wdata_o  = s_wdata;
    assign bus.s_wstrb_o  = s_wstrb;
    assign bus.m_ready_o  = m_ready;
    assign bus.m_rvalid_o = m_rvalid;
    assign bus.m_rdata_o  = bus.s_rdata_i;

    assign busy_o       = (state_q != ST_IDLE);
    assign err_o        = err_q;
    assign err_master_o = err_master_q;

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// tb/tb_ext_mem_arbiter.sv - self-checking bench for ext_mem_arbiter
module tb_ext_mem_arbiter;

    localparam int N   = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 8;

    logic       clk;
    logic       arst_n;
    logic       cke;
    logic       busy;
    logic       err;
    logic [1:0] err_master;

    int checks = 0;
    int errors = 0;

    ext_mem_arbiter_if #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    ext_mem_arbiter #(
        .N_MASTERS    (N),
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .RESP_TIMEOUT (TMO)
    ) dut (
        .clk_i        (clk),
        .arst_n_i     (arst_n),
        .cke_i        (cke),
        .bus          (bus),
        .busy_o       (busy),
        .err_o        (err),
        .err_master_o (err_master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req(input int k, input logic v, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
        bus.m_avalid_i[k]          = v;
        bus.m_addr_i[k*AW +: AW]   = a;
        bus.m_wdata_i[k*DW +: DW]  = d;
        bus.m_wstrb_i[k*SW +: SW]  = s;
    endtask

    task automatic clear_inputs();
        bus.m_avalid_i = '0;
        bus.m_addr_i   = '0;
        bus.m_wdata_i  = '0;
        bus.m_wstrb_i  = '0;
        bus.s_rdata_i  = '0;
        bus.s_rvalid_i = 1'b0;
        bus.s_ready_i  = 1'b0;
    endtask

    task automatic apply_reset();
        arst_n = 1'b0;
        cke    = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        cke    = 1'b1;
        clear_inputs();
        bus.m_avalid_i = 3'b011;
        bus.s_ready_i  = 1'b1;
        bus.s_rvalid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.m_ready_o !== 3'b000) begin errors++; $display("FAIL reset_m_ready got=%b exp=000", bus.m_ready_o); end
        checks++; if (bus.m_rvalid_o !== 3'b000) begin errors++; $display("FAIL reset_m_rvalid got=%b exp=000", bus.m_rvalid_o); end
        checks++; if (bus.s_avalid_o !== 1'b0) begin errors++; $display("FAIL reset_s_avalid got=%b exp=0", bus.s_avalid_o); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (err_master !== 2'd0) begin errors++; $display("FAIL reset_err_master got=%0d exp=0", err_master); end
        clear_inputs();
    endtask

    task automatic test_single_read();
        apply_reset();
        set_req(0, 1'b1, 32'h0000_1000, 32'h0, 4'h0);
        bus.s_ready_i = 1'b1;
        @(negedge clk);
        checks++; if (bus.m_ready_o !== 3'b001) begin errors++; $display("FAIL rd_ready got=%b exp=001", bus.m_ready_o); end
        checks++; if (bus.s_avalid_o !== 1'b1) begin errors++; $display("FAIL rd_s_avalid got=%b exp=1", bus.s_avalid_o); end
        checks++; if (bus.s_addr_o !== 32'h0000_1000) begin errors++; $display("FAIL rd_s_addr got=%h exp=00001000", bus.s_addr_o); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy0 got=%b exp=0", busy); end
        @(posedge clk); #1;
        set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
        bus.s_ready_i = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin
                bus.s_rvalid_i = 1'b1;
                bus.s_rdata_i  = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rd_busy c=%0d got=%b exp=1", c, busy); end
            checks++; if (bus.m_rvalid_o !== ((c == 3) ? 3'b001 : 3'b000)) begin errors++; $display("FAIL rd_rvalid c=%0d got=%b", c, bus.m_rvalid_o); end
            @(posedge clk); #1;
        end
        checks++; if (bus.m_rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rdata got=%h exp=deadbeef", bus.m_rdata_o); end
        bus.s_rvalid_i = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_busy_end got=%b exp=0", busy); end
        checks++; if (bus.m_rvalid_o !== 3'b000) begin errors++; $display("FAIL rd_rvalid_end got=%b exp=000", bus.m_rvalid_o); end
        checks++; if (bus.s_addr_o !== 32'h0) begin errors++; $display("FAIL rd_idle_addr got=%h exp=0", bus.s_addr_o); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        set_req(0, 1'b1, 32'hA000_0000, 32'h1111_1111, 4'hF);
        set_req(1, 1'b1, 32'hB000_0000, 32'h2222_2222, 4'hF);
        bus.s_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if (bus.m_ready_o !== 3'(1 << (i % 2))) begin errors++; $display("FAIL b2b_grant i=%0d got=%b", i, bus.m_ready_o); end
            checks++; if (bus.s_addr_o !== ((i % 2 == 0) ? 32'hA000_0000 : 32'hB000_0000)) begin errors++; $display("FAIL b2b_addr i=%0d got=%h", i, bus.s_addr_o); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy i=%0d got=%b exp=0", i, busy); end
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    task automatic test_read_blocks_other();
        apply_reset();
        set_req(1, 1'b1, 32'h0000_2000, 32'h0, 4'h0);
        bus.s_ready_i = 1'b1;
        @(negedge clk);
        checks++; if (bus.m_ready_o !== 3'b010) begin errors++; $display("FAIL blk_grant1 got=%b exp=010", bus.m_ready_o); end
        @(posedge clk); #1;
        set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
        set_req(0, 1'b1, 32'h0000_3000, 32'h5555_AAAA, 4'h3);
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) begin
                bus.s_rvalid_i = 1'b1;
                bus.s_rdata_i  = 32'h1234_5678;
            end
            @(negedge clk);
            checks++; if (bus.m_ready_o !== 3'b000) begin errors++; $display("FAIL blk_ready c=%0d got=%b exp=000", c, bus.m_ready_o); end
            checks++; if (bus.s_avalid_o !== 1'b0) begin errors++; $display("FAIL blk_s_avalid c=%0d got=%b exp=0", c, bus.s_avalid_o); end
            checks++; if (bus.m_rvalid_o !== ((c == 4) ? 3'b010 : 3'b000)) begin errors++; $display("FAIL blk_rvalid c=%0d got=%b", c, bus.m_rvalid_o); end
            @(posedge clk); #1;
        end
        bus.s_rvalid_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.m_ready_o !== 3'b001) begin errors++; $display("FAIL blk_grant0 got=%b exp=001", bus.m_ready_o); end
        checks++; if (bus.s_addr_o !== 32'h0000_3000) begin errors++; $display("FAIL blk_addr0 got=%h exp=00003000", bus.s_addr_o); end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_addr_hold();
        apply_reset();
        set_req(0, 1'b1, 32'h0000_4000, 32'hCAFE_0000, 4'hF);
        bus.s_ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (bus.s_addr_o !== 32'h0000_4000) begin errors++; $display("FAIL hold_addr c=%0d got=%h exp=00004000", c, bus.s_addr_o); end
            checks++; if (bus.m_ready_o !== 3'b000) begin errors++; $display("FAIL hold_ready c=%0d got=%b exp=000", c, bus.m_ready_o); end
            checks++; if (busy !== (c > 0)) begin errors++; $display("FAIL hold_busy c=%0d got=%b", c, busy); end
            @(posedge clk); #1;
            set_req(1, 1'b1, 32'h0000_5000, 32'hBEEF_0000, 4'hF);
        end
        bus.s_ready_i = 1'b1;
        @(negedge clk);
        checks++; if (bus.m_ready_o !== 3'b001) begin errors++; $display("FAIL hold_accept got=%b exp=001", bus.m_ready_o); end
        checks++; if (bus.s_wdata_o !== 32'hCAFE_0000) begin errors++; $display("FAIL hold_wdata got=%h exp=cafe0000", bus.s_wdata_o); end
        @(posedge clk); #1;
        set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        checks++; if (bus.m_ready_o !== 3'b010) begin errors++; $display("FAIL hold_next got=%b exp=010", bus.m_ready_o); end
        checks++; if (bus.s_addr_o !== 32'h0000_5000) begin errors++; $display("FAIL hold_next_addr got=%h exp=00005000", bus.s_addr_o); end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_timeout();
        int pulses;
        pulses = 0;
        apply_reset();
        set_req(1, 1'b1, 32'h0000_6000, 32'h0, 4'h0);
        bus.s_ready_i = 1'b1;
        @(negedge clk);
        checks++; if (bus.m_ready_o !== 3'b010) begin errors++; $display("FAIL tmo_accept got=%b exp=010", bus.m_ready_o); end
        @(posedge clk); #1;
        clear_inputs();
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (err === 1'b1) pulses++;
            checks++; if (err !== (k == TMO)) begin errors++; $display("FAIL tmo_err k=%0d got=%b", k, err); end
            checks++; if (busy !== (k < TMO)) begin errors++; $display("FAIL tmo_busy k=%0d got=%b", k, busy); end
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL tmo_pulses got=%0d exp=1", pulses); end
        checks++; if (err_master !== 2'd1) begin errors++; $display("FAIL tmo_err_master got=%0d exp=1", err_master); end
        @(posedge clk); #1;
        bus.s_rvalid_i = 1'b1;
        bus.s_rdata_i  = 32'h0BAD_0BAD;
        @(negedge clk);
        checks++; if (bus.m_rvalid_o !== 3'b000) begin errors++; $display("FAIL tmo_stray got=%b exp=000", bus.m_rvalid_o); end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_reset_cke();
        apply_reset();
        set_req(0, 1'b1, 32'h0000_7000, 32'h0, 4'h0);
        bus.s_ready_i = 1'b1;
        @(posedge clk); #1;
        clear_inputs();
        #2;
        arst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got=%b exp=0", busy); end
        cke = 1'b0;
        set_req(0, 1'b1, 32'h0000_8000, 32'h77, 4'hF);
        set_req(1, 1'b1, 32'h0000_9000, 32'h88, 4'hF);
        bus.s_ready_i  = 1'b1;
        bus.s_rvalid_i = 1'b1;
        @(negedge clk);
        arst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++; if (bus.s_avalid_o !== 1'b0) begin errors++; $display("FAIL cke_s_avalid c=%0d got=%b exp=0", c, bus.s_avalid_o); end
            checks++; if (bus.m_ready_o !== 3'b000) begin errors++; $display("FAIL cke_ready c=%0d got=%b exp=000", c, bus.m_ready_o); end
            checks++; if (bus.m_rvalid_o !== 3'b000) begin errors++; $display("FAIL cke_rvalid c=%0d got=%b exp=000", c, bus.m_rvalid_o); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cke_busy c=%0d got=%b exp=0", c, busy); end
        end
        @(posedge clk); #1;
        cke = 1'b1;
        bus.s_rvalid_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.m_ready_o !== 3'b001) begin errors++; $display("FAIL cke_resume got=%b exp=001", bus.m_ready_o); end
        checks++; if (bus.s_addr_o !== 32'h0000_8000) begin errors++; $display("FAIL cke_resume_addr got=%h exp=00008000", bus.s_addr_o); end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    // Transaction-level reference: a request is either held for an address
    // phase, waiting for its read response, or absent; the grant order is the
    // rotating scan from the last served master.
    task automatic test_random();
        int held, resp, age, last, who, m_errm, e_errm;
        logic m_err, e_err, n_err, e_busy, e_sav;
        logic [N-1:0]    pend, e_ready, e_rvalid;
        logic [AW-1:0]   addr [N];
        logic [DW-1:0]   wdata [N];
        logic [SW-1:0]   strb [N];
        logic [AW-1:0]   e_addr;
        logic [DW-1:0]   e_wdata;
        logic [SW-1:0]   e_wstrb;
        apply_reset();
        held = -1; resp = -1; age = 0; last = N - 1;
        m_err = 1'b0; m_errm = 0; pend = '0;
        for (int k = 0; k < N; k++) begin
            addr[k] = '0; wdata[k] = '0; strb[k] = '0;
        end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int k = 0; k < N; k++) begin
                if (!pend[k] && $urandom_range(0, 2) == 0) begin
                    pend[k]  = 1'b1;
                    addr[k]  = $urandom;
                    wdata[k] = $urandom;
                    strb[k]  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                end
                set_req(k, pend[k], addr[k], wdata[k], strb[k]);
            end
            bus.s_ready_i  = ($urandom_range(0, 3) != 0);
            bus.s_rvalid_i = ($urandom_range(0, 5) == 0);
            bus.s_rdata_i  = $urandom;
            @(negedge clk);
            e_err = m_err; e_errm = m_errm;
            e_busy = (held >= 0) || (resp >= 0);
            e_ready = '0; e_rvalid = '0; e_sav = 1'b0;
            e_addr = '0; e_wdata = '0; e_wstrb = '0; n_err = 1'b0;
            if (resp >= 0) begin
                if (bus.s_rvalid_i) begin
                    e_rvalid[resp] = 1'b1;
                    resp = -1;
                end else if (age == TMO - 1) begin
                    n_err = 1'b1; m_errm = resp; resp = -1;
                end else begin
                    age++;
                end
            end else begin
                who = held;
                for (int i = 1; i <= N; i++) begin
                    if (who < 0 && pend[(last + i) % N]) who = (last + i) % N;
                end
                if (who >= 0) begin
                    e_sav = 1'b1; e_addr = addr[who]; e_wdata = wdata[who]; e_wstrb = strb[who];
                    if (bus.s_ready_i) begin
                        e_ready[who] = 1'b1;
                        last = who; held = -1; pend[who] = 1'b0;
                        if (strb[who] == '0) begin resp = who; age = 0; end
                    end else begin
                        held = who;
                    end
                end
            end
            m_err = n_err;
            checks++; if (bus.m_ready_o !== e_ready) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, bus.m_ready_o, e_ready); end
            checks++; if (bus.m_rvalid_o !== e_rvalid) begin errors++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", cyc, bus.m_rvalid_o, e_rvalid); end
            checks++; if (bus.s_avalid_o !== e_sav) begin errors++; $display("FAIL rnd_s_avalid cyc=%0d got=%b exp=%b", cyc, bus.s_avalid_o, e_sav); end
            checks++; if (busy !== e_busy) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy); end
            checks++; if (err !== e_err) begin errors++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, err, e_err); end
            checks++; if (err_master !== 2'(e_errm)) begin errors++; $display("FAIL rnd_err_master cyc=%0d got=%0d exp=%0d", cyc, err_master, e_errm); end
            checks++; if (bus.m_rdata_o !== bus.s_rdata_i) begin errors++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, bus.m_rdata_o, bus.s_rdata_i); end
            if (e_sav) begin
                checks++; if ({bus.s_addr_o, bus.s_wdata_o, bus.s_wstrb_o} !== {e_addr, e_wdata, e_wstrb}) begin
                    errors++; $display("FAIL rnd_fields cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc, bus.s_addr_o, bus.s_wdata_o, bus.s_wstrb_o, e_addr, e_wdata, e_wstrb);
                end
            end
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    initial begin
        arst_n = 1'b0;
        cke    = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_back_to_back();
        test_read_blocks_other();
        test_addr_hold();
        test_timeout();
        test_reset_cke();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
